// File: rtl/ber_run_ctrl.sv
// ber_run_ctrl: sequences one bit-error-rate measurement run over the
// PRBS31 TX/channel/noise/DFE/RX/checker chain. Each run flushes the chain
// in reset, lets it warm up, snapshots the checker counters, then measures
// a window of bits. The window ends on completion, stall timeout, abort or
// (optionally) an error-count early stop.
//
// Optional feature: define BER_EARLY_STOP_EN to stop a run early once the
// window error count reaches a non-zero max_errors.
//
// Ports
//   clk, rst                   single clock, synchronous active-high reset
//   start, abort               run request (IDLE only) / terminate run
//   measure_bits, max_errors   window length and early-stop threshold,
//                              both latched on an accepted start
//   total_bits,                running counters from the PRBS31 checker
//   total_bit_errors
//   chain_en, chain_rstn       enable / active-low reset to the chain
//   busy, done                 run in progress / one-cycle end-of-run pulse
//   result_bits,               bits and errors counted in the window
//   result_errors
//   status                     0 complete, 1 timeout, 2 abort, 3 early stop
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | chain held in reset, waiting for start
// FLUSH   | chain in reset for FLUSH_CYCLES
// WARMUP  | chain running for WARMUP_CYCLES so pipelines/DFE settle
// ARM     | one cycle, capture checker baselines
// MEASURE | results track counter deltas until the run ends
// DONE    | one cycle, done pulse, chain frozen (en=0, rstn=1)

module ber_run_ctrl #(
   parameter int FLUSH_CYCLES   = 8,
   parameter int WARMUP_CYCLES  = 256,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] measure_bits,
   input  logic [31:0] max_errors,
   input  logic [31:0] total_bits,
   input  logic [31:0] total_bit_errors,
   output logic        chain_en,
   output logic        chain_rstn,
   output logic        busy,
   output logic        done,
   output logic [31:0] result_bits,
   output logic [31:0] result_errors,
   output logic [1:0]  status
);

   typedef enum logic [2:0] {
      S_IDLE, S_FLUSH, S_WARMUP, S_ARM, S_MEASURE, S_DONE
   } state_t;

   localparam logic [1:0] ST_COMPLETE = 2'd0;
   localparam logic [1:0] ST_TIMEOUT  = 2'd1;
   localparam logic [1:0] ST_ABORT    = 2'd2;
   localparam logic [1:0] ST_EARLY    = 2'd3;

   localparam int PH_MAX  = (FLUSH_CYCLES > WARMUP_CYCLES) ? FLUSH_CYCLES : WARMUP_CYCLES;
   localparam int TMR_W   = $clog2(PH_MAX + 1);
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [TMR_W-1:0]   FLUSH_LOAD = TMR_W'(FLUSH_CYCLES - 1);
   localparam logic [TMR_W-1:0]   WARM_LOAD  = TMR_W'(WARMUP_CYCLES - 1);
   localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(TIMEOUT_CYCLES - 1);

   state_t               state, state_nx;
   logic [1:0]           end_status;
   logic [TMR_W-1:0]     ph_tmr;
   logic [STALL_W-1:0]   stall_tmr;
   logic [31:0]          prev_bits;
   logic [31:0]          meas_len;
   logic [31:0]          base_bits;
   logic [31:0]          base_err;
   logic                 bits_moved;
   logic                 stall_watch;
   logic                 stall_hit;
   logic                 early_hit;
   logic                 state_change;

   assign bits_moved   = (total_bits != prev_bits);
   assign stall_watch  = (state == S_WARMUP) || (state == S_MEASURE);
   assign stall_hit    = stall_watch && (stall_tmr == '0) && !bits_moved;
   assign state_change = (state_nx != state);

`ifdef BER_EARLY_STOP_EN
   logic [31:0] max_err;

   always_ff @(posedge clk) begin
      if (rst)
         max_err <= '0;
      else if (state == S_IDLE && start)
         max_err <= max_errors;
   end

   // A zero threshold disables early stop.
   assign early_hit = (max_err != '0) && (result_errors >= max_err);
`else
   logic unused_max_errors;
   assign unused_max_errors = ^max_errors;
   assign early_hit         = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      end_status = ST_COMPLETE;
      case (state)
         S_IDLE:
            if (start) state_nx = S_FLUSH;
         S_FLUSH:
            if (abort) begin
               state_nx   = S_DONE;
               end_status = ST_ABORT;
            end else if (ph_tmr == '0) begin
               state_nx = S_WARMUP;
            end
         S_WARMUP:
            if (abort) begin
               state_nx   = S_DONE;
               end_status = ST_ABORT;
            end else if (stall_hit) begin
               state_nx   = S_DONE;
               end_status = ST_TIMEOUT;
            end else if (ph_tmr == '0) begin
               state_nx = S_ARM;
            end
         S_ARM:
            if (abort) begin
               state_nx   = S_DONE;
               end_status = ST_ABORT;
            end else begin
               state_nx = S_MEASURE;
            end
         S_MEASURE:
            if (abort) begin
               state_nx   = S_DONE;
               end_status = ST_ABORT;
            end else if (stall_hit) begin
               state_nx   = S_DONE;
               end_status = ST_TIMEOUT;
            end else if (early_hit) begin
               state_nx   = S_DONE;
               end_status = ST_EARLY;
            end else if (result_bits >= meas_len) begin
               state_nx = S_DONE;
            end
         S_DONE:
            state_nx = S_IDLE;
         default:
            state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      chain_en   = 1'b0;
      chain_rstn = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         S_IDLE:
            busy = 1'b0;
         S_FLUSH: ;
         S_WARMUP, S_ARM, S_MEASURE: begin
            chain_en   = 1'b1;
            chain_rstn = 1'b1;
         end
         S_DONE: begin
            chain_rstn = 1'b1;
            done       = 1'b1;
         end
         default:
            busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ph_tmr    <= '0;
         stall_tmr <= STALL_LOAD;
         prev_bits <= '0;
      end else begin
         prev_bits <= total_bits;

         if (state_change && state_nx == S_FLUSH)
            ph_tmr <= FLUSH_LOAD;
         else if (state_change && state_nx == S_WARMUP)
            ph_tmr <= WARM_LOAD;
         else if (ph_tmr != '0)
            ph_tmr <= ph_tmr - TMR_W'(1);

         if (state_change || bits_moved || !stall_watch)
            stall_tmr <= STALL_LOAD;
         else if (stall_tmr != '0)
            stall_tmr <= stall_tmr - STALL_W'(1);
      end
   end

   // Results only update while the run continues, so the values seen at
   // DONE are the ones that satisfied (or were current at) the exit.
   always_ff @(posedge clk) begin
      if (rst) begin
         meas_len      <= '0;
         base_bits     <= '0;
         base_err      <= '0;
         result_bits   <= '0;
         result_errors <= '0;
         status        <= ST_COMPLETE;
      end else begin
         if (state == S_IDLE && start) begin
            meas_len      <= measure_bits;
            result_bits   <= '0;
            result_errors <= '0;
            status        <= ST_COMPLETE;
         end
         if (state == S_ARM) begin
            base_bits <= total_bits;
            base_err  <= total_bit_errors;
         end
         // Modulo-2^32 deltas stay correct across checker counter wrap.
         if (state == S_MEASURE && state_nx == S_MEASURE) begin
            result_bits   <= total_bits - base_bits;
            result_errors <= total_bit_errors - base_err;
         end
         if (state_change && state_nx == S_DONE)
            status <= end_status;
      end
   end

endmodule

// File: doc/ber_run_ctrl.md
BER_RUN_CTRL -- requirements
Module: ber_run_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 8: cycles the datapath chain is held in reset before each run.
REQ-002 Parameter WARMUP_CYCLES, default 256: cycles the chain runs before measurement, covering pipeline, ISI and DFE settling.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles without any change on total_bits before the run is declared stalled.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  run request; sampled only in IDLE.
REQ-007 abort  in  1  terminate the current run.
REQ-008 measure_bits  in  32  measurement window length in bits; latched on accepted start.
REQ-009 max_errors  in  32  early-stop error threshold; latched on accepted start; used only with BER_EARLY_STOP_EN.
REQ-010 total_bits  in  32  running bit count from the PRBS31 checker.
REQ-011 total_bit_errors  in  32  running error count from the PRBS31 checker.
REQ-012 chain_en  out  1  enable to the PRBS generator and noise wrapper.
REQ-013 chain_rstn  out  1  active-low reset to the whole TX/channel/noise/DFE/RX/checker chain.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at the end of each run.
REQ-016 result_bits / result_errors  out  32 each  bits and errors counted in the window.
REQ-017 status  out  2  run outcome: 0 = complete, 1 = timeout, 2 = abort, 3 = early stop.

Function
REQ-018 The FSM SHALL have these states: IDLE, FLUSH, WARMUP, ARM, MEASURE, DONE.
REQ-019 IDLE: start=1 SHALL latch measure_bits and max_errors, clear result_bits, result_errors and status, and move to FLUSH on the next cycle.
REQ-020 FLUSH SHALL hold chain_rstn=0 and chain_en=0 for exactly FLUSH_CYCLES cycles, then move to WARMUP.
REQ-021 WARMUP SHALL drive chain_rstn=1 and chain_en=1 for exactly WARMUP_CYCLES cycles, then move to ARM.
REQ-022 ARM SHALL last 1 cycle and capture the baselines base_bits=total_bits and base_err=total_bit_errors.
REQ-023 MEASURE: every cycle, result_bits SHALL equal total_bits-base_bits and result_errors SHALL equal total_bit_errors-base_err.
REQ-024 Both subtractions SHALL be modulo 2^32, so checker counter wrap yields correct deltas.
REQ-025 MEASURE SHALL move to DONE in the cycle after the registered result_bits is >= the latched measure_bits; if measure_bits=0, the run ends with result_bits=0 or near it.
REQ-026 The stall counter SHALL clear on any cycle where total_bits differs from its previous-cycle value, and on state entry.
REQ-027 In WARMUP or MEASURE, the stall counter reaching TIMEOUT_CYCLES SHALL move the FSM to DONE with status=1.
REQ-028 abort=1 in FLUSH, WARMUP, ARM or MEASURE SHALL move the FSM to DONE next cycle with status=2; results keep their last values, which are 0 if abort occurs before MEASURE.
REQ-029 abort in IDLE or DONE SHALL be ignored.
REQ-030 Priority when conditions coincide: abort > timeout > early stop > window complete.
REQ-031 DONE SHALL last 1 cycle, assert done=1 and drive chain_en=0 with chain_rstn=1 (chain frozen), then return to IDLE.
REQ-032 IDLE SHALL drive chain_en=0 and chain_rstn=0.
REQ-033 Results and status SHALL hold from DONE until the next accepted start.
REQ-034 start asserted while busy SHALL be ignored; no queuing.

Reset
REQ-035 rst=1 SHALL force IDLE and clear all counters, baselines, results, status, done and busy, with chain_en=0 and chain_rstn=0.
REQ-036 rst asserted mid-run SHALL abandon the run without a done pulse.

Configuration
REQ-037 With macro BER_EARLY_STOP_EN defined, MEASURE SHALL move to DONE with status=3 once result_errors >= the latched max_errors and max_errors != 0.
REQ-038 Without BER_EARLY_STOP_EN, max_errors SHALL be unused, status 3 SHALL never occur, and no comparator logic SHALL be synthesized.

Verification
REQ-039 rst, then start with measure_bits=1000 and a checker model adding 1 bit/cycle, 0 errors -> chain_rstn low 8 cycles, WARMUP 256 cycles, done pulse with result_bits=1000, result_errors=0, status=0.
REQ-040 Checker model with total_bits preset to 0xFFFFFF00 at ARM, measure_bits=512 -> result_bits=512 despite wrap.
REQ-041 total_bits frozen during MEASURE -> done exactly 1024 cycles later, status=1.
REQ-042 abort pulse in WARMUP -> done next cycle, status=2, result_bits=0; start pulses while busy -> ignored.
REQ-043 BER_EARLY_STOP_EN defined, max_errors=5, an error injected every 10 bits, measure_bits=10000 -> done at result_errors=5, status=3.
REQ-044 rst asserted mid-MEASURE -> IDLE next cycle, no done pulse, all outputs at reset values.
